// File: rtl/ysyx_mem_arbiter_if.sv
// ysyx_mem_arbiter_if: IFU/LSU request ports and the shared memory-bus port of the arbiter
interface ysyx_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   ifu_araddr;
  logic                ifu_arvalid;
  logic [DATA_W-1:0]   ifu_rdata;
  logic                ifu_rvalid;
  logic                ifu_err;
  logic [ADDR_W-1:0]   lsu_araddr;
  logic                lsu_arvalid;
  logic [DATA_W-1:0]   lsu_rdata;
  logic                lsu_rvalid;
  logic [ADDR_W-1:0]   lsu_awaddr;
  logic                lsu_awvalid;
  logic [DATA_W-1:0]   lsu_wdata;
  logic [DATA_W/8-1:0] lsu_wstrb;
  logic                lsu_bvalid;
  logic                lsu_err;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_arvalid;
  logic                mem_awvalid;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_rvalid;
  logic                mem_bvalid;
  modport slave (
    input  ifu_araddr, ifu_arvalid, lsu_araddr, lsu_arvalid, lsu_awaddr, lsu_awvalid,
           lsu_wdata, lsu_wstrb, mem_rdata, mem_rvalid, mem_bvalid,
    output ifu_rdata, ifu_rvalid, ifu_err, lsu_rdata, lsu_rvalid, lsu_bvalid, lsu_err,
           mem_addr, mem_arvalid, mem_awvalid, mem_wdata, mem_wstrb
  );
  modport master (
    output ifu_araddr, ifu_arvalid, lsu_araddr, lsu_arvalid, lsu_awaddr, lsu_awvalid,
           lsu_wdata, lsu_wstrb, mem_rdata, mem_rvalid, mem_bvalid,
    input  ifu_rdata, ifu_rvalid, ifu_err, lsu_rdata, lsu_rvalid, lsu_bvalid, lsu_err,
           mem_addr, mem_arvalid, mem_awvalid, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/ysyx_mem_arbiter.sv
// ysyx_mem_arbiter: round-robin IFU/LSU arbiter onto one memory bus, with a
// per-transaction timeout that answers for a silent slave with an error response.
module ysyx_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic               clk,
  input logic               rst,
  ysyx_mem_arbiter_if.slave bus
);
  localparam int CW      = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam int TO_LAST = TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0;
  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;
  state_e              state_q, state_d, lsu_st;
  logic                last_q, last_d;
  logic                mask_q, mask_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ifu_req, lsu_req, tmo, rd_hit, wr_hit, done;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  // last_q: 0 = IFU served last, 1 = LSU; mask_q blocks that master for one IDLE cycle
  assign ifu_req = bus.ifu_arvalid && !(mask_q && !last_q);
  assign lsu_req = (bus.lsu_arvalid || bus.lsu_awvalid) && !(mask_q && last_q);
  assign lsu_st  = bus.lsu_awvalid ? LSU_WR : LSU_RD;
  assign tmo     = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TO_LAST));
  assign rd_hit  = (state_q == IFU_RD || state_q == LSU_RD) && bus.mem_rvalid;
  assign wr_hit  = state_q == LSU_WR && bus.mem_bvalid;
  assign done    = state_q != IDLE && (rd_hit || wr_hit || tmo);
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    mask_d  = 1'b0;
    cnt_d   = state_q == IDLE ? '0 : cnt_q + 1'b1;
    if (state_q == IDLE) begin
      if (ifu_req && (!lsu_req || last_q)) state_d = IFU_RD;
      else if (lsu_req) state_d = lsu_st;
    end else if (done) begin
      state_d = IDLE;
      last_d  = state_q != IFU_RD;
      mask_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      mask_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end
  assign addr  = state_q == IFU_RD ? bus.ifu_araddr :
                 state_q == LSU_RD ? bus.lsu_araddr :
                 state_q == LSU_WR ? bus.lsu_awaddr : '0;
  assign wdata = state_q == LSU_WR ? bus.lsu_wdata : '0;
  assign wstrb = state_q == LSU_WR ? bus.lsu_wstrb : '0;
  assign bus.mem_addr    = addr;
  assign bus.mem_wdata   = wdata;
  assign bus.mem_wstrb   = wstrb;
  assign bus.mem_arvalid = state_q == IFU_RD || state_q == LSU_RD;
  assign bus.mem_awvalid = state_q == LSU_WR;
  // a real response in the timeout cycle wins, so err only flags a forced completion
  assign bus.ifu_rvalid  = state_q == IFU_RD && done;
  assign bus.ifu_err     = state_q == IFU_RD && tmo && !rd_hit;
  assign bus.ifu_rdata   = state_q == IFU_RD && rd_hit ? bus.mem_rdata : '0;
  assign bus.lsu_rvalid  = state_q == LSU_RD && done;
  assign bus.lsu_bvalid  = state_q == LSU_WR && done;
  assign bus.lsu_err     = (state_q == LSU_RD || state_q == LSU_WR) && tmo && !(rd_hit || wr_hit);
  assign bus.lsu_rdata   = state_q == LSU_RD && rd_hit ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// tb_ysyx_mem_arbiter: directed scenarios plus a randomized run scored against a
// transaction-level model of the arbitration, timeout and masking rules.
module tb_ysyx_mem_arbiter;
  localparam int AW = 32, DW = 32, TO = 16;
  typedef logic [138:0] ovec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0;
  ysyx_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ysyx_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic ovec_t outs();
    return {bus.mem_arvalid, bus.mem_awvalid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
            bus.ifu_rvalid, bus.ifu_err, bus.ifu_rdata,
            bus.lsu_rvalid, bus.lsu_bvalid, bus.lsu_err, bus.lsu_rdata};
  endfunction

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic idle_in();
    bus.ifu_araddr = '0; bus.ifu_arvalid = 0;
    bus.lsu_araddr = '0; bus.lsu_arvalid = 0;
    bus.lsu_awaddr = '0; bus.lsu_awvalid = 0; bus.lsu_wdata = '0; bus.lsu_wstrb = '0;
    bus.mem_rdata = '0; bus.mem_rvalid = 0; bus.mem_bvalid = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 0;
    nxt(); nxt();
    rst = 1;
  endtask

  task automatic test_reset();
    idle_in();
    #1 rst = 0;
    bus.ifu_arvalid = 1; bus.lsu_awvalid = 1; bus.mem_rvalid = 1; bus.mem_bvalid = 1;
    for (int i = 0; i < 2; i++) begin
      smp();
      checks++;
      if (outs() !== '0) begin errors++; $display("FAIL reset_outs got %h exp 0", outs()); end
    end
    do_reset();
  endtask

  task automatic test_ifu_read();
    do_reset();
    bus.ifu_araddr = 32'h8000_0000; bus.ifu_arvalid = 1;
    smp();
    checks++;
    if (bus.mem_arvalid !== 1'b0) begin errors++; $display("FAIL t1_idle arvalid got %b exp 0", bus.mem_arvalid); end
    nxt(); smp();
    checks++;
    if ({bus.mem_arvalid, bus.mem_addr, bus.ifu_rvalid} !== {1'b1, 32'h8000_0000, 1'b0}) begin
      errors++; $display("FAIL t1_grant got %b %h %b exp 1 80000000 0", bus.mem_arvalid, bus.mem_addr, bus.ifu_rvalid);
    end
    nxt();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h0000_0413;
    smp();
    checks++;
    if ({bus.ifu_rvalid, bus.ifu_err, bus.ifu_rdata, bus.lsu_rvalid, bus.lsu_rdata} !== {2'b10, 32'h413, 1'b0, 32'h0}) begin
      errors++; $display("FAIL t1_resp got %b%b %h %b %h exp 10 00000413 0 0", bus.ifu_rvalid, bus.ifu_err, bus.ifu_rdata, bus.lsu_rvalid, bus.lsu_rdata);
    end
    nxt();
    bus.ifu_arvalid = 0; bus.mem_rvalid = 0;
    smp();
    checks++;
    if ({bus.mem_arvalid, bus.ifu_rvalid} !== 2'b00) begin
      errors++; $display("FAIL t1_back_idle got %b%b exp 00", bus.mem_arvalid, bus.ifu_rvalid);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] seq [4];
    logic saw = 0, prev = 0;
    int n = 0, lst = 0, who;
    do_reset();
    for (int i = 0; i < 4; i++) seq[i] = '0;
    bus.ifu_araddr = 32'h1000; bus.lsu_araddr = 32'h2000;
    bus.ifu_arvalid = 1; bus.lsu_arvalid = 1;
    for (int c = 0; c < 14; c++) begin
      bus.mem_rvalid = saw; bus.mem_rdata = 32'(c);
      smp();
      if (bus.mem_arvalid && !prev && n < 4) begin seq[n] = bus.mem_addr; n++; end
      checks++;
      if (bus.ifu_rvalid && bus.lsu_rvalid) begin errors++; $display("FAIL rr_dual_rvalid c=%0d got 11 exp not both", c); end
      prev = bus.mem_arvalid; saw = bus.mem_arvalid;
      nxt();
    end
    for (int i = 0; i < 4; i++) begin
      who = 1 - lst;
      checks++;
      if (seq[i] !== (who == 1 ? 32'h2000 : 32'h1000)) begin
        errors++; $display("FAIL rr_order %0d got %h exp %h", i, seq[i], who == 1 ? 32'h2000 : 32'h1000);
      end
      lst = who;
    end
    idle_in();
  endtask

  task automatic test_write();
    do_reset();
    bus.lsu_awaddr = 32'hA000_03F8; bus.lsu_wdata = 32'h41; bus.lsu_wstrb = 4'b0001; bus.lsu_awvalid = 1;
    bus.lsu_araddr = 32'h5555_0000; bus.lsu_arvalid = 1;
    smp(); nxt();
    bus.mem_rvalid = 1;
    smp();
    checks++;
    if ({bus.mem_arvalid, bus.mem_awvalid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.lsu_rvalid, bus.lsu_bvalid}
        !== {2'b01, 32'hA000_03F8, 32'h41, 4'b0001, 2'b00}) begin
      errors++; $display("FAIL t3_wr_bus got %b%b %h %h %b %b%b", bus.mem_arvalid, bus.mem_awvalid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.lsu_rvalid, bus.lsu_bvalid);
    end
    nxt();
    bus.mem_rvalid = 0; bus.mem_bvalid = 1;
    smp();
    checks++;
    if ({bus.lsu_bvalid, bus.lsu_err, bus.lsu_rvalid, bus.ifu_rvalid} !== 4'b1000) begin
      errors++; $display("FAIL t3_bresp got %b%b%b%b exp 1000", bus.lsu_bvalid, bus.lsu_err, bus.lsu_rvalid, bus.ifu_rvalid);
    end
    nxt();
    idle_in();
    smp();
    checks++;
    if (bus.mem_awvalid !== 1'b0) begin errors++; $display("FAIL t3_idle awvalid got %b exp 0", bus.mem_awvalid); end
  endtask

  task automatic test_timeout();
    logic hit;
    do_reset();
    bus.ifu_araddr = 32'h8000_0100; bus.ifu_arvalid = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    smp(); nxt();
    bus.lsu_araddr = 32'h3000; bus.lsu_arvalid = 1;
    for (int k = 1; k <= TO; k++) begin
      hit = (k == TO);
      smp();
      checks++;
      if ({bus.mem_arvalid, bus.mem_addr, bus.ifu_rvalid, bus.ifu_err, bus.ifu_rdata, bus.lsu_rvalid}
          !== {1'b1, 32'h8000_0100, hit, hit, 32'h0, 1'b0}) begin
        errors++; $display("FAIL t4_tmo k=%0d got %b %h %b%b %h %b exp rvalid/err=%b", k, bus.mem_arvalid, bus.mem_addr, bus.ifu_rvalid, bus.ifu_err, bus.ifu_rdata, bus.lsu_rvalid, hit);
      end
      nxt();
    end
    bus.ifu_arvalid = 0;
    smp();
    checks++;
    if (bus.mem_arvalid !== 1'b0) begin errors++; $display("FAIL t4_idle arvalid got %b exp 0", bus.mem_arvalid); end
    nxt(); smp();
    checks++;
    if ({bus.mem_arvalid, bus.mem_addr} !== {1'b1, 32'h3000}) begin
      errors++; $display("FAIL t4_lsu_grant got %b %h exp 1 00003000", bus.mem_arvalid, bus.mem_addr);
    end
    nxt();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h55;
    smp();
    checks++;
    if ({bus.lsu_rvalid, bus.lsu_err, bus.lsu_rdata, bus.ifu_rvalid} !== {2'b10, 32'h55, 1'b0}) begin
      errors++; $display("FAIL t4_lsu_resp got %b%b %h %b exp 10 00000055 0", bus.lsu_rvalid, bus.lsu_err, bus.lsu_rdata, bus.ifu_rvalid);
    end
    nxt();
    idle_in();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.lsu_awaddr = 32'h4000; bus.lsu_wdata = 32'h7; bus.lsu_wstrb = 4'hF; bus.lsu_awvalid = 1;
    smp(); nxt(); smp();
    checks++;
    if (bus.mem_awvalid !== 1'b1) begin errors++; $display("FAIL t5_pre awvalid got %b exp 1", bus.mem_awvalid); end
    rst = 0;
    #1;
    checks++;
    if ({bus.mem_awvalid, bus.mem_arvalid} !== 2'b00) begin
      errors++; $display("FAIL t5_async got %b%b exp 00", bus.mem_awvalid, bus.mem_arvalid);
    end
    bus.lsu_awvalid = 0;
    nxt();
    rst = 1; bus.mem_bvalid = 1;
    for (int i = 0; i < 2; i++) begin
      smp();
      checks++;
      if ({bus.lsu_bvalid, bus.lsu_err, bus.mem_awvalid} !== 3'b000) begin
        errors++; $display("FAIL t5_late_b %0d got %b%b%b exp 000", i, bus.lsu_bvalid, bus.lsu_err, bus.mem_awvalid);
      end
      nxt();
    end
    idle_in();
  endtask

  task automatic test_mask();
    do_reset();
    bus.ifu_araddr = 32'h100; bus.ifu_arvalid = 1;
    smp(); nxt();
    bus.mem_rvalid = 1; bus.lsu_araddr = 32'h200; bus.lsu_arvalid = 1;
    smp();
    checks++;
    if (bus.ifu_rvalid !== 1'b1) begin errors++; $display("FAIL t6_ifu_done got %b exp 1", bus.ifu_rvalid); end
    nxt();
    bus.mem_rvalid = 0;
    smp(); nxt(); smp();
    checks++;
    if ({bus.mem_arvalid, bus.mem_addr} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL t6_lsu_grant got %b %h exp 1 00000200", bus.mem_arvalid, bus.mem_addr);
    end
    nxt();
    bus.mem_rvalid = 1;
    smp();
    checks++;
    if ({bus.lsu_rvalid, bus.ifu_rvalid} !== 2'b10) begin
      errors++; $display("FAIL t6_lsu_done got %b%b exp 10", bus.lsu_rvalid, bus.ifu_rvalid);
    end
    nxt();
    bus.lsu_arvalid = 0; bus.mem_rvalid = 0;
    smp(); nxt();
    bus.mem_rvalid = 1;
    smp();
    checks++;
    if ({bus.ifu_rvalid, bus.mem_addr} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL t6_ifu_again got %b %h exp 1 00000100", bus.ifu_rvalid, bus.mem_addr);
    end
    nxt();
    bus.mem_rvalid = 0;
    smp(); nxt(); smp();
    checks++;
    if (bus.mem_arvalid !== 1'b0) begin errors++; $display("FAIL t6_masked got %b exp 0", bus.mem_arvalid); end
    nxt(); smp();
    checks++;
    if (bus.mem_arvalid !== 1'b1) begin errors++; $display("FAIL t6_unmasked got %b exp 1", bus.mem_arvalid); end
    nxt();
    idle_in();
  endtask

  task automatic test_random();
    int m_who = -1, m_last = 0, m_done = -10, m_start = 0, lw = 0;
    bit m_wr = 0, ip = 0, lp = 0, ir, lr, hit, late, silent;
    logic e_ar, e_aw, e_irv, e_ierr, e_lrv, e_lbv, e_lerr;
    logic [31:0] e_addr, e_wd, e_ird, e_lrd;
    logic [3:0] e_ws;
    ovec_t exp;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!ip && $urandom % 3 == 0) begin ip = 1; bus.ifu_araddr = $urandom; end
      else if (ip && $urandom % 32 == 0) ip = 0;
      if (!lp && $urandom % 3 == 0) begin
        lp = 1; lw = int'($urandom % 3);
        bus.lsu_araddr = $urandom; bus.lsu_awaddr = $urandom; bus.lsu_wdata = $urandom; bus.lsu_wstrb = 4'($urandom);
      end else if (lp && $urandom % 32 == 0) lp = 0;
      bus.ifu_arvalid = ip;
      bus.lsu_arvalid = lp && lw != 1;
      bus.lsu_awvalid = lp && lw != 0;
      silent = (c / 80) % 4 == 3;
      bus.mem_rvalid = !silent && $urandom % 3 == 0;
      bus.mem_bvalid = !silent && $urandom % 3 == 0;
      bus.mem_rdata = $urandom;
      smp();
      {e_ar, e_aw, e_irv, e_ierr, e_lrv, e_lbv, e_lerr} = '0;
      {e_addr, e_wd, e_ird, e_lrd, e_ws} = '0;
      if (m_who < 0) begin
        ir = bus.ifu_arvalid && !(m_done == c - 1 && m_last == 0);
        lr = (bus.lsu_arvalid || bus.lsu_awvalid) && !(m_done == c - 1 && m_last == 1);
        if (ir || lr) begin
          m_who = (ir && lr) ? 1 - m_last : (lr ? 1 : 0);
          m_wr = m_who == 1 && bus.lsu_awvalid;
          m_start = c + 1;
        end
      end else begin
        e_ar = !m_wr; e_aw = m_wr;
        e_addr = m_who == 0 ? bus.ifu_araddr : (m_wr ? bus.lsu_awaddr : bus.lsu_araddr);
        if (m_wr) begin e_wd = bus.lsu_wdata; e_ws = bus.lsu_wstrb; end
        hit = m_wr ? bus.mem_bvalid : bus.mem_rvalid;
        late = (c - m_start) == TO - 1;
        if (hit || late) begin
          if (m_who == 0) begin e_irv = 1; e_ierr = !hit; e_ird = hit ? bus.mem_rdata : '0; end
          else begin
            e_lrv = !m_wr; e_lbv = m_wr; e_lerr = !hit;
            e_lrd = (hit && !m_wr) ? bus.mem_rdata : '0;
          end
          m_last = m_who; m_done = c; m_who = -1;
        end
      end
      exp = {e_ar, e_aw, e_addr, e_wd, e_ws, e_irv, e_ierr, e_ird, e_lrv, e_lbv, e_lerr, e_lrd};
      checks++;
      if (outs() !== exp) begin errors++; $display("FAIL rand c=%0d got %h exp %h", c, outs(), exp); end
      if (e_irv) begin ip = $urandom % 4 == 0; bus.ifu_araddr = $urandom; end
      if (e_lrv || e_lbv) begin lp = $urandom % 4 == 0; lw = int'($urandom % 3); bus.lsu_araddr = $urandom; bus.lsu_awaddr = $urandom; end
      nxt();
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_reset_mid();
    test_mask();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
